ext_pipe: RTL and testbench
===========================

// Module: ext_pipe
//
// PURPOSE
// Parametrised, registered immediate extender with valid/ready handshake on both sides.
// Sits between decode and the operand-select stage of the pipelined datapath.
// Accepts one IMM_W-bit immediate plus a mode per cycle and returns a DATA_W-bit extended value.
// Holds up to two results in an internal skid FIFO, so full throughput survives downstream stalls.
//
// PARAMETERS
// IMM_W   16  immediate width; legal range 1..DATA_W
// DATA_W  32  output width
// SHAMT   2   left-shift amount for the shifted modes; legal range 0..DATA_W-1
//
// PORTS
// clk        in   1       clock, rising edge
// reset      in   1       synchronous, active-high
// in_valid   in   1       upstream has a request
// in_ready   out  1       block can accept a request this cycle
// imm        in   IMM_W   immediate
// EOp        in   3       extension mode
// out_valid  out  1       ext holds a valid result
// out_ready  in   1       downstream takes the result this cycle
// ext        out  DATA_W  extended result at the FIFO head
// err        out  1       sticky flag: a reserved EOp was accepted
// count      out  2       occupancy, 0..2
//
// BEHAVIOUR
// - Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
// - Modes, applied to the accepted imm; any bits shifted out past DATA_W are dropped:
//   - 000  sign-extend.
//   - 001  zero-extend.
//   - 010  {imm, (DATA_W-IMM_W) zeros}.
//   - 011  sign-extend, then << SHAMT.
//   - 100  zero-extend, then << SHAMT.
//   - 101..111  reserved: the result is 0 and err is set.
// - Transfer rules:
//   - Push when in_valid && in_ready.
//   - Pop when out_valid && out_ready.
// - in_ready = (count != 2). It depends on registered state only, never on out_ready.
// - out_valid = (count != 0). ext shows the head entry; ext is 0 when count == 0.
// - Latency is exactly 1 cycle: a push at edge N is visible on ext/out_valid after edge N.
//   There is no combinational path from the inputs to ext.
// - Order is strict FIFO. Entries are never dropped or duplicated.
// - Count update by case:
//   - count == 0, push: count becomes 1.
//   - count == 1, push and pop on the same edge: count stays 1; the new entry becomes head.
//   - count == 2: in_ready is 0, so no push; a pop makes count 1 and the tail becomes head.
//   - No push and no pop: everything holds. ext is stable while out_valid && !out_ready.
// - Inputs are ignored when in_valid == 0, including X on imm/EOp.
// - err: set on the edge that pushes a reserved EOp; cleared only by reset.
// - Reset at any time, including mid-transfer: at the next edge count=0, out_valid=0,
//   in_ready=1, ext=0, err=0. In-flight entries are discarded; a push in the reset cycle is ignored.
// - IMM_W == DATA_W: modes 000, 001 and 010 all return imm unchanged.
//
// TESTING
// - Modes, default params, imm=16'h8001, one push each, out_ready=1:
//   - EOp=000 -> ext=32'hFFFF8001.
//   - EOp=001 -> ext=32'h00008001.
//   - EOp=010 -> ext=32'h80010000.
//   - EOp=011 -> ext=32'hFFFE0004.
//   - EOp=100 -> ext=32'h00020004.
//   - Each result appears 1 cycle after its push.
// - Backpressure: out_ready=0, push imm=16'h0001 then 16'h0002 with EOp=001:
//   - After 2 edges: count=2, in_ready=0, ext=32'h1.
//   - A third push attempt is not accepted.
//   - Raise out_ready: outputs are 1 then 2, in order.
// - Streaming: in_valid=1 and out_ready=1 for 8 cycles with imm=0..7, EOp=000:
//   - 8 results 0..7 appear, one per cycle; count stays 1.
// - Reserved op: push EOp=110 with imm=16'hFFFF:
//   - ext=0 and err=1 next cycle.
//   - err stays 1 through later valid ops until reset.
// - Reset mid-operation: with count=2 and err=1, assert reset for 1 cycle:
//   - Next cycle: count=0, out_valid=0, in_ready=1, ext=0, err=0.
//   - A push during the reset cycle never emerges.
// - Parametrised build IMM_W=12, DATA_W=16, SHAMT=4, imm=12'h801:
//   - EOp=000 -> 16'hF801.
//   - EOp=010 -> 16'h8010.
//   - EOp=011 -> 16'h8010.

Source files
------------

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: request/response bundle for the immediate extender.
//   Request side : in_valid, in_ready, imm, EOp
//   Response side: out_valid, out_ready, ext, err, count
// master drives requests and out_ready; slave is the extender itself.
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm;
  logic [2:0]        EOp;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext;
  logic              err;
  logic [1:0]        count;

  modport master (
    output in_valid, imm, EOp, out_ready,
    input  in_ready, out_valid, ext, err, count
  );

  modport slave (
    input  in_valid, imm, EOp, out_ready,
    output in_ready, out_valid, ext, err, count
  );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender with a two-entry skid FIFO.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : ext_pipe_if.slave
//            in_valid/in_ready/imm/EOp   - request handshake
//            out_valid/out_ready/ext     - response handshake, ext = FIFO head
//            err                         - sticky, set when a reserved EOp is accepted
//            count                       - FIFO occupancy 0..2
// The extended value is computed on the input side and stored, so ext comes
// straight from a register (gated to 0 when empty) with one cycle of latency.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  ext_pipe_if.slave  bus
);

  // Sign extension is built as zero extension plus a high-bit mask; when
  // IMM_W == DATA_W the mask collapses to zero, so no zero-width replication.
  function automatic logic signed [DATA_W-1:0] extend(
    input logic [IMM_W-1:0] imm_in,
    input logic [2:0]       eop
  );
    logic        [DATA_W-1:0] zx;
    logic        [DATA_W-1:0] hi_mask;
    logic signed [DATA_W-1:0] sx;
    zx      = DATA_W'(imm_in);
    hi_mask = ~((DATA_W'(1) << IMM_W) - DATA_W'(1));
    sx      = signed'(imm_in[IMM_W-1] ? (zx | hi_mask) : zx);
    case (eop)
      3'b000:  extend = sx;
      3'b001:  extend = signed'(zx);
      3'b010:  extend = signed'(zx << (DATA_W - IMM_W));
      3'b011:  extend = sx <<< SHAMT;
      3'b100:  extend = signed'(zx << SHAMT);
      default: extend = '0;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [2:0] eop);
    is_reserved = (eop > 3'b100);
  endfunction

  logic signed [DATA_W-1:0] head_p0;
  logic signed [DATA_W-1:0] tail_p0;
  logic signed [DATA_W-1:0] res_p0;
  logic [1:0]               count_q;
  logic                     err_q;
  logic                     push;
  logic                     pop;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign res_p0        = extend(bus.imm, bus.EOp);

  // ---- stage boundary: request -> FIFO storage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      if (push && is_reserved(bus.EOp))
        err_q <= 1'b1;
      case (count_q)
        2'd0: if (push) count_q <= 2'd1;
        2'd1: begin
          if (push && !pop)      count_q <= 2'd2;
          else if (!push && pop) count_q <= 2'd0;
        end
        default: if (pop) count_q <= 2'd1;
      endcase
    end
  end

  // Data registers carry no reset; an empty FIFO is hidden by the count gate on ext.
  always_ff @(posedge clk) begin
    case (count_q)
      2'd0: if (push) head_p0 <= res_p0;
      2'd1: begin
        if (push && pop)  head_p0 <= res_p0;
        else if (push)    tail_p0 <= res_p0;
      end
      default: if (pop) head_p0 <= tail_p0;
    endcase
  end

  assign bus.ext   = (count_q != 2'd0) ? head_p0 : '0;
  assign bus.err   = err_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ext_pipe_if #(.IMM_W(16), .DATA_W(32)) bus ();
  ext_pipe_if #(.IMM_W(12), .DATA_W(16)) bus2 ();

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SHAMT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  ext_pipe #(.IMM_W(12), .DATA_W(16), .SHAMT(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.imm = 16'h1234; bus.EOp = 3'b001; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.imm = '0; bus2.EOp = '0; bus2.out_ready = 1'b1;
    step(); step();
    reset = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.count !== 2'd0)   begin errors++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.ext !== 32'h0)      begin errors++; $display("FAIL rst_ext: got %h want 0", bus.ext); end
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    // X on imm/EOp while idle must be ignored
    bus.imm = 'x; bus.EOp = 'x;
    step();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL idle_x_count: got %0d want 0", bus.count); end
    checks++; if (bus.err !== 1'b0)   begin errors++; $display("FAIL idle_x_err: got %b want 0", bus.err); end
  endtask

  task automatic test_modes();
    logic [31:0] exp_tab [5];
    exp_tab[0] = 32'hFFFF8001; exp_tab[1] = 32'h00008001; exp_tab[2] = 32'h80010000;
    exp_tab[3] = 32'hFFFE0004; exp_tab[4] = 32'h00020004;
    bus.out_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      bus.in_valid = 1'b1; bus.imm = 16'h8001; bus.EOp = 3'(m);
      step();
      checks++; if (bus.ext !== exp_tab[m]) begin errors++; $display("FAIL mode%0d_ext: got %h want %h", m, bus.ext, exp_tab[m]); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b want 1", m, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL modes_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0; bus.EOp = 3'b001;
    bus.in_valid = 1'b1; bus.imm = 16'h0001; step();
    bus.imm = 16'h0002; step();
    checks++; if (bus.count !== 2'd2)    begin errors++; $display("FAIL bp_count: got %0d want 2", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.ext !== 32'h1)     begin errors++; $display("FAIL bp_head: got %h want 1", bus.ext); end
    bus.imm = 16'h0003; step();
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL bp_third_count: got %0d want 2", bus.count); end
    checks++; if (bus.ext !== 32'h1)  begin errors++; $display("FAIL bp_stable: got %h want 1", bus.ext); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    checks++; if (bus.ext !== 32'h2)  begin errors++; $display("FAIL bp_second: got %h want 2", bus.ext); end
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL bp_count1: got %0d want 1", bus.count); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1; bus.EOp = 3'b000;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.imm = 16'(i);
      step();
      checks++; if (bus.ext !== 32'(i))  begin errors++; $display("FAIL stream%0d_ext: got %h want %h", i, bus.ext, 32'(i)); end
      checks++; if (bus.count !== 2'd1)  begin errors++; $display("FAIL stream%0d_count: got %0d want 1", i, bus.count); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL stream_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_reserved();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.imm = 16'hFFFF; bus.EOp = 3'b110;
    step();
    checks++; if (bus.ext !== 32'h0)      begin errors++; $display("FAIL rsv_ext: got %h want 0", bus.ext); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rsv_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.err !== 1'b1)       begin errors++; $display("FAIL rsv_err: got %b want 1", bus.err); end
    bus.imm = 16'h0005; bus.EOp = 3'b001;
    step();
    checks++; if (bus.ext !== 32'h5) begin errors++; $display("FAIL rsv_next_ext: got %h want 5", bus.ext); end
    checks++; if (bus.err !== 1'b1)  begin errors++; $display("FAIL rsv_sticky: got %b want 1", bus.err); end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rsv_sticky_idle: got %b want 1", bus.err); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0; bus.EOp = 3'b001;
    bus.in_valid = 1'b1; bus.imm = 16'h0011; step();
    bus.imm = 16'h0022; step();
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", bus.count); end
    reset = 1'b1; bus.imm = 16'h00AA;
    step();
    reset = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.count !== 2'd0)     begin errors++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.ext !== 32'h0)      begin errors++; $display("FAIL mid_ext: got %h want 0", bus.ext); end
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL mid_err: got %b want 0", bus.err); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_param();
    logic [2:0]  ops [3];
    logic [15:0] exp_tab [3];
    ops[0] = 3'b000; exp_tab[0] = 16'hF801;
    ops[1] = 3'b010; exp_tab[1] = 16'h8010;
    ops[2] = 3'b011; exp_tab[2] = 16'h8010;
    bus2.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus2.in_valid = 1'b1; bus2.imm = 12'h801; bus2.EOp = ops[k];
      step();
      checks++; if (bus2.ext !== exp_tab[k]) begin errors++; $display("FAIL param_op%0d: got %h want %h", ops[k], bus2.ext, exp_tab[k]); end
    end
    bus2.in_valid = 1'b0;
    step();
    checks++; if (bus2.count !== 2'd0) begin errors++; $display("FAIL param_drain: got %0d want 0", bus2.count); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_reserved();
    test_reset_mid();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
